regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Shares the architectural register file's single read port and single write port among several requesters in the out-of-order core.
- Read clients are dispatch operand fetch slots; write clients are commit sources.
- Round-robin read arbitration with a response tag.
- Fixed-priority write arbitration.
- Same-cycle write-to-read forwarding, because the register file read samples pre-write contents.
- x0 protection.

Parameters:
- NUM_RD, 4, number of read requesters (≥2).
- NUM_WR, 2, number of write requesters (≥1).
- XLEN, 32, data width.
- IDX_W, 5, register index width.
- ID_W, 2, read requester id width; equals clog2(NUM_RD).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rd_req  in  NUM_RD  per-requester read request
- rd_idx  in  NUM_RD*IDX_W  packed read indices; slot i at [i*IDX_W +: IDX_W]
- rd_gnt  out  NUM_RD  one-hot grant, combinational, same cycle as request
- rsp_valid  out  1  read response valid
- rsp_id  out  ID_W  requester id of the response
- rsp_data  out  XLEN  read data
- rsp_vld  out  1  register valid flag returned with the data
- wr_req  in  NUM_WR  per-writer write request
- wr_idx  in  NUM_WR*IDX_W  packed write indices
- wr_data  in  NUM_WR*XLEN  packed write data
- wr_gnt  out  NUM_WR  one-hot write grant, combinational
- rf_write_en  out  1  to register file
- rf_write_idx  out  IDX_W  to register file
- rf_write_data  out  XLEN  to register file
- rf_read_en  out  1  to register file
- rf_read_idx  out  IDX_W  to register file
- rf_read_data  in  XLEN  from register file, 1-cycle latency
- rf_read_valid  in  1  from register file

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_vld=0; RR pointer=0; forward register cleared.
- Reset is asynchronous and mid-operation: an in-flight read is dropped, and no response appears in the cycle after reset deasserts.
- Read arbitration:
  - Round-robin starting at pointer p.
  - Grant the first i in p, p+1, … (mod NUM_RD) with rd_req[i]=1.
  - On grant, p ← granted+1 (wraps at NUM_RD). With no request, p is unchanged.
  - Worst-case wait for a continuously requesting slot is NUM_RD−1 cycles.
  - Requesters hold req and idx stable until granted; an ungranted request has no side effect.
- Read port drive: rf_read_en = |rd_gnt; rf_read_idx = index of the granted slot.
- Read latency: grant in cycle T → rsp_valid=1 in T+1, with rsp_id = granted id registered at T.
  - rsp_data/rsp_vld normally equal rf_read_data/rf_read_valid.
  - With no grant at T, rsp_valid=0 at T+1 and rsp_data/rsp_id hold their previous values.
- Write arbitration:
  - Fixed priority, lowest index wins; wr_gnt is one-hot.
  - Losing writers see gnt=0 and must hold.
  - rf_write_en = granted && idx≠0; rf_write_idx/rf_write_data come from the winner.
- x0 rule:
  - A granted write to index 0 is consumed (gnt=1) but never reaches the register file.
  - A read of index 0 returns rsp_data=0, rsp_vld=1 regardless of the register file.
- Forwarding:
  - Case: at cycle T a read and a write are both granted with the same nonzero index.
  - Register the write data; at T+1 drive rsp_data = that data and rsp_vld=1, overriding the register file output.
  - A write in T+1 does not affect a read granted in T.
- Back-to-back reads on consecutive cycles are fully pipelined: one response per cycle.
- No buffering: the block holds at most one in-flight read (a single pipeline stage).

Decomposition:
- Shared package:
  - XLEN and IDX_W constants.
  - ZERO_REG index constant (5'd0).
  - Packed-slice helper macro or function for idx/data extraction.
- One sub-module, rr_arbiter:
  - Parameterised N.
  - Inputs: req, advance.
  - Outputs: one-hot gnt, granted id.
  - Owns the pointer register and the async reset.
- Write priority arbiter and forwarding logic stay inline.

Test Plan:
- All four read slots request continuously, idx 1..4, with the register file preloaded x1..x4=0x11..0x44 → grants cycle 0,1,2,3,0…; each rsp one cycle after its grant with correct id/data; no slot waits more than 3 cycles.
- Writer0 and writer1 both request (x5=0xAAAA, x6=0xBBBB) → writer0 granted first cycle, writer1 next; register file later reads x5=0xAAAA, x6=0xBBBB.
- Same-cycle read x7 and write x7=0xDEADBEEF, with the old value 0x0 → rsp_data=0xDEADBEEF, rsp_vld=1, at T+1.
- Write x0=0xFFFFFFFF granted → rf_write_en stays 0; subsequent read x0 → rsp_data=0, rsp_vld=1.
- Assert rst while a read is granted with rsp pending → rsp_valid=0 immediately and after release; RR pointer restarts at slot 0.
- Idle cycle between reads → rsp_valid=0 in the gap; rsp_id/rsp_data hold their last values.

Source files
------------

// File: rtl/regfile_port_arbiter_pkg.sv
// regfile_port_arbiter_pkg: shared widths, the x0 index and packed-slice helpers
package regfile_port_arbiter_pkg;
    localparam int XLEN = 32;
    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] ZERO_REG = 5'd0;
    localparam int PACK_W = 256;
    function automatic logic [IDX_W-1:0] idx_slice(input logic [PACK_W-1:0] v, input int i);
        return v[i*IDX_W +: IDX_W];
    endfunction
    function automatic logic [XLEN-1:0] data_slice(input logic [PACK_W-1:0] v, input int i);
        return v[i*XLEN +: XLEN];
    endfunction
endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; the pointer moves past each granted slot
module rr_arbiter #(
    parameter int N = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);
    logic [ID_W-1:0] ptr;
    logic found;
    always_comb begin
        gnt = '0;
        gnt_id = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                gnt_id = ID_W'((int'(ptr) + k) % N);
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (advance && found)
            ptr <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
    end
endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares the register file read/write ports among dispatch and commit,
// with same-cycle write-to-read forwarding and x0 protection
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2,
    parameter int XLEN = regfile_port_arbiter_pkg::XLEN,
    parameter int IDX_W = regfile_port_arbiter_pkg::IDX_W,
    parameter int ID_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RD-1:0]         rd_req,
    input  logic [NUM_RD*IDX_W-1:0]   rd_idx,
    output logic [NUM_RD-1:0]         rd_gnt,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [XLEN-1:0]           rsp_data,
    output logic                      rsp_vld,
    input  logic [NUM_WR-1:0]         wr_req,
    input  logic [NUM_WR*IDX_W-1:0]   wr_idx,
    input  logic [NUM_WR*XLEN-1:0]    wr_data,
    output logic [NUM_WR-1:0]         wr_gnt,
    output logic                      rf_write_en,
    output logic [IDX_W-1:0]          rf_write_idx,
    output logic [XLEN-1:0]           rf_write_data,
    output logic                      rf_read_en,
    output logic [IDX_W-1:0]          rf_read_idx,
    input  logic [XLEN-1:0]           rf_read_data,
    input  logic                      rf_read_valid
);
    logic [ID_W-1:0] rd_id;
    logic [IDX_W-1:0] rd_sel_idx, wr_sel_idx;
    logic [XLEN-1:0] wr_sel_data, fwd_data, hold_data, cur_data;
    logic wr_any, fwd_hit, pend, pend_zero, pend_fwd, hold_vld, cur_vld;

    rr_arbiter #(.N(NUM_RD), .ID_W(ID_W)) u_rd_arb (
        .clk(clk), .rst(rst), .req(rd_req), .advance(1'b1), .gnt(rd_gnt), .gnt_id(rd_id)
    );

    always_comb begin
        rd_sel_idx = ZERO_REG;
        for (int i = 0; i < NUM_RD; i++)
            if (rd_gnt[i]) rd_sel_idx = idx_slice(PACK_W'(rd_idx), i);
    end

    // Descending scan so the lowest-index requester overwrites and wins
    always_comb begin
        wr_gnt = '0;
        wr_sel_idx = ZERO_REG;
        wr_sel_data = '0;
        for (int i = NUM_WR - 1; i >= 0; i--) begin
            if (wr_req[i]) begin
                wr_gnt = '0;
                wr_gnt[i] = 1'b1;
                wr_sel_idx = idx_slice(PACK_W'(wr_idx), i);
                wr_sel_data = data_slice(PACK_W'(wr_data), i);
            end
        end
    end

    assign wr_any = |wr_req;
    assign rf_write_en = wr_any && wr_sel_idx != ZERO_REG;
    assign rf_write_idx = wr_sel_idx;
    assign rf_write_data = wr_sel_data;
    assign rf_read_en = |rd_gnt;
    assign rf_read_idx = rd_sel_idx;
    // The register file samples pre-write contents, so a colliding write must be bypassed
    assign fwd_hit = rf_read_en && rf_write_en && rd_sel_idx == wr_sel_idx;

    assign cur_data = pend_zero ? '0 : pend_fwd ? fwd_data : rf_read_data;
    assign cur_vld = pend_zero || pend_fwd || rf_read_valid;
    assign rsp_valid = pend;
    assign rsp_data = pend ? cur_data : hold_data;
    assign rsp_vld = pend ? cur_vld : hold_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            pend_zero <= 1'b0;
            pend_fwd <= 1'b0;
            fwd_data <= '0;
            rsp_id <= '0;
            hold_data <= '0;
            hold_vld <= 1'b0;
        end else begin
            pend <= rf_read_en;
            if (rf_read_en) begin
                rsp_id <= rd_id;
                pend_zero <= rd_sel_idx == ZERO_REG;
                pend_fwd <= fwd_hit;
            end
            if (fwd_hit) fwd_data <= wr_sel_data;
            if (pend) begin
                hold_data <= cur_data;
                hold_vld <= cur_vld;
            end
        end
    end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: table-driven check of arbitration, forwarding, x0 and reset
module tb_regfile_port_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] rd_req = '0, rd_gnt;
    logic [19:0] rd_idx = '0;
    logic rsp_valid, rsp_vld, rf_write_en, rf_read_en;
    logic [1:0] rsp_id, wr_req = '0, wr_gnt;
    logic [31:0] rsp_data, rf_write_data, rf_read_data = '0;
    logic [9:0] wr_idx = '0;
    logic [63:0] wr_data = '0;
    logic [4:0] rf_write_idx, rf_read_idx;
    logic rf_read_valid = 1'b0;
    logic [31:0] mem [32];
    logic rvalid [32];
    int checks = 0, errors = 0;

    regfile_port_arbiter dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_idx(rd_idx), .rd_gnt(rd_gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_vld(rsp_vld),
        .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rf_write_en(rf_write_en), .rf_write_idx(rf_write_idx), .rf_write_data(rf_write_data),
        .rf_read_en(rf_read_en), .rf_read_idx(rf_read_idx), .rf_read_data(rf_read_data),
        .rf_read_valid(rf_read_valid)
    );

    always #5 clk = ~clk;

    // Register file model: one-cycle read latency, read sees pre-write contents
    always @(posedge clk) begin
        if (rf_read_en) begin
            rf_read_data <= mem[rf_read_idx];
            rf_read_valid <= rvalid[rf_read_idx];
        end
        if (rf_write_en) begin
            mem[rf_write_idx] <= rf_write_data;
            rvalid[rf_write_idx] <= 1'b1;
        end
    end

    typedef struct {
        logic [3:0] rq; logic [19:0] ri; logic [1:0] wq; logic [9:0] wi; logic [63:0] wd;
        logic [3:0] g; logic [1:0] wg; logic we; logic rv; logic [1:0] id; logic [31:0] d; logic v;
    } vec_t;
    vec_t vec [15];

    function automatic vec_t row(logic [3:0] rq, logic [19:0] ri, logic [1:0] wq, logic [9:0] wi,
                                 logic [63:0] wd, logic [3:0] g, logic [1:0] wg, logic we,
                                 logic rv, logic [1:0] id, logic [31:0] d, logic v);
        row = '{rq, ri, wq, wi, wd, g, wg, we, rv, id, d, v};
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    localparam logic [19:0] ALL = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [9:0] W56 = {5'd6, 5'd5};
    localparam logic [63:0] DAB = {32'hBBBB, 32'hAAAA};

    initial begin
        int last [4];
        int max_gap;
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            rvalid[i] = 1'b0;
        end
        for (int i = 1; i <= 4; i++) begin
            mem[i] = 32'h11 * i;
            rvalid[i] = 1'b1;
        end
        mem[0] = 32'hDEAD;
        vec[0]  = row(4'hF, ALL, 2'b00, '0, '0, 4'b0001, 2'b00, 0, 0, 2'd0, 32'h0, 0);
        vec[1]  = row(4'hF, ALL, 2'b00, '0, '0, 4'b0010, 2'b00, 0, 1, 2'd0, 32'h11, 1);
        vec[2]  = row(4'hF, ALL, 2'b00, '0, '0, 4'b0100, 2'b00, 0, 1, 2'd1, 32'h22, 1);
        vec[3]  = row(4'hF, ALL, 2'b00, '0, '0, 4'b1000, 2'b00, 0, 1, 2'd2, 32'h33, 1);
        vec[4]  = row(4'hF, ALL, 2'b00, '0, '0, 4'b0001, 2'b00, 0, 1, 2'd3, 32'h44, 1);
        vec[5]  = row(4'h0, '0, 2'b11, W56, DAB, 4'b0000, 2'b01, 1, 1, 2'd0, 32'h11, 1);
        vec[6]  = row(4'h0, '0, 2'b10, W56, DAB, 4'b0000, 2'b10, 1, 0, 2'd0, 32'h11, 1);
        vec[7]  = row(4'h2, 20'd5 << 5, 2'b00, '0, '0, 4'b0010, 2'b00, 0, 0, 2'd0, 32'h11, 1);
        vec[8]  = row(4'h4, 20'd6 << 10, 2'b00, '0, '0, 4'b0100, 2'b00, 0, 1, 2'd1, 32'hAAAA, 1);
        vec[9]  = row(4'h8, 20'd7 << 15, 2'b01, 10'd7, 64'hDEADBEEF, 4'b1000, 2'b01, 1, 1, 2'd2, 32'hBBBB, 1);
        vec[10] = row(4'h0, '0, 2'b01, 10'd0, 64'hFFFFFFFF, 4'b0000, 2'b01, 0, 1, 2'd3, 32'hDEADBEEF, 1);
        vec[11] = row(4'h1, '0, 2'b00, '0, '0, 4'b0001, 2'b00, 0, 0, 2'd3, 32'hDEADBEEF, 1);
        vec[12] = row(4'h2, 20'd7 << 5, 2'b00, '0, '0, 4'b0010, 2'b00, 0, 1, 2'd0, 32'h0, 1);
        vec[13] = row(4'h0, '0, 2'b10, 10'd7 << 5, {32'h12345678, 32'h0}, 4'b0000, 2'b10, 1, 1, 2'd1, 32'hDEADBEEF, 1);
        vec[14] = row(4'h0, '0, 2'b00, '0, '0, 4'b0000, 2'b00, 0, 0, 2'd1, 32'hDEADBEEF, 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            rd_req = vec[i].rq; rd_idx = vec[i].ri;
            wr_req = vec[i].wq; wr_idx = vec[i].wi; wr_data = vec[i].wd;
            #1;
            chk($sformatf("row%0d rd_gnt", i), 64'(rd_gnt), 64'(vec[i].g));
            chk($sformatf("row%0d wr_gnt", i), 64'(wr_gnt), 64'(vec[i].wg));
            chk($sformatf("row%0d rf_write_en", i), 64'(rf_write_en), 64'(vec[i].we));
            chk($sformatf("row%0d rsp_valid", i), 64'(rsp_valid), 64'(vec[i].rv));
            chk($sformatf("row%0d rsp_id", i), 64'(rsp_id), 64'(vec[i].id));
            chk($sformatf("row%0d rsp_data", i), 64'(rsp_data), 64'(vec[i].d));
            chk($sformatf("row%0d rsp_vld", i), 64'(rsp_vld), 64'(vec[i].v));
        end
        // Reset while a response is pending; pointer was left at slot 2
        @(posedge clk);
        #1 rd_req = 4'hF; rd_idx = ALL; wr_req = '0;
        #1 chk("pre_rst gnt", 64'(rd_gnt), 64'h4);
        @(posedge clk);
        #1 chk("pre_rst rsp_valid", 64'(rsp_valid), 64'h1);
        chk("pre_rst rsp_data", 64'(rsp_data), 64'h33);
        rst = 1'b1;
        #1 chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst rsp_id", 64'(rsp_id), 64'h0);
        chk("rst rsp_data", 64'(rsp_data), 64'h0);
        @(posedge clk);
        #2 rst = 1'b0; rd_req = '0;
        @(posedge clk);
        #1 chk("post_rst rsp_valid", 64'(rsp_valid), 64'h0);
        // Continuous requests from every slot after reset: pointer restarts at 0
        for (int i = 0; i < 4; i++) last[i] = -1;
        max_gap = 0;
        rd_req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            #1 chk($sformatf("rr%0d gnt", k), 64'(rd_gnt), 64'(4'b1 << (k % 4)));
            for (int s = 0; s < 4; s++) begin
                if (rd_gnt[s]) begin
                    if (last[s] >= 0 && k - last[s] > max_gap) max_gap = k - last[s];
                    last[s] = k;
                end
            end
            if (k > 0) begin
                chk($sformatf("rr%0d rsp_id", k), 64'(rsp_id), 64'((k - 1) % 4));
                chk($sformatf("rr%0d rsp_data", k), 64'(rsp_data), 64'(32'h11 * ((k - 1) % 4 + 1)));
            end
        end
        chk("rr max_gap", 64'(max_gap), 64'd4);
        rd_req = '0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
